instr_issuer: RTL and testbench

//  Initiator side of the processor control-unit instruction interface. Fetches 9-bit IIIXXXYYY words

---
 rtl/instr_issuer_pkg.sv | 40 ++++
 rtl/instr_issuer_exec_watchdog.sv | 31 +++
 rtl/instr_issuer.sv | 155 +++++++++++++++
 tb/tb_instr_issuer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer: opcodes, FSM state encoding
// and opcode classification helpers.
// Build option: SINGLE_STEP_EN adds the PAUSE state used for single stepping.
package instr_issuer_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_HALT = 3'b000;
    localparam op_t OP_MV   = 3'b001;
    localparam op_t OP_MVI  = 3'b010;
    localparam op_t OP_ADD  = 3'b011;
    localparam op_t OP_SUB  = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_FIMM,
        S_LIMM,
        S_ISSUE,
        S_EXEC,
        S_HALT,
        S_ERROR
`ifdef SINGLE_STEP_EN
        ,
        S_PAUSE
`endif
    } state_t;

    // Legal opcodes are 000..100; anything above OP_SUB is illegal.
    function automatic logic is_legal_op(input op_t op);
        return (op <= OP_SUB);
    endfunction

    // Only mvi carries a second (immediate) word.
    function automatic logic has_imm(input op_t op);
        return (op == OP_MVI);
    endfunction

endpackage

// File: rtl/instr_issuer_exec_watchdog.sv
// Execution watchdog: counts cycles while enabled and flags expiry on the
// TIMEOUT-th enabled cycle. Clear has priority over counting.
// Build option: none (SINGLE_STEP_EN does not affect this block).
module instr_issuer_exec_watchdog #(
    parameter int TIMEOUT = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    // Expiry is flagged during the TIMEOUT-th consecutive enabled cycle.
    assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Cycle counter; saturates at the limit so it cannot wrap back to zero.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: fetches IIIXXXYYY words from a synchronous ROM, drives
// them to the processor with RUN, waits for DONE and advances the PC.
// mvi fetches its immediate word and presents it during execution.
// Build option: SINGLE_STEP_EN adds input STEP and a PAUSE state after each
// retired instruction.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 9,
    parameter int TIMEOUT = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
`ifdef SINGLE_STEP_EN
    input  logic              STEP,
`endif
    output logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic [DATA_W-1:0] DIN,
    output logic              RUN,
    input  logic              DONE,
    output logic              BUSY,
    output logic              HALTED,
    output logic              ERROR,
    output logic [7:0]        INSTR_COUNT
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] w_din_next;
    logic              r_run;
    logic              w_run_next;
    logic [7:0]        r_instr_count;
    logic              w_expired;
    logic              w_wd_clr;
    logic              w_wd_en;
    op_t               w_mem_op;
    op_t               w_ir_op;

    assign w_mem_op = MEM_DATA[DATA_W-1 -: 3];
    assign w_ir_op  = r_ir[DATA_W-1 -: 3];
    assign w_wd_en  = (r_state == S_EXEC);
    assign w_wd_clr = !w_wd_en;

    instr_issuer_exec_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_exec_watchdog (
        .i_clk     (CLK),
        .i_reset   (RESET),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );

    // Next-state logic for the fetch/issue/execute sequence.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves the signal unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (START) w_next_state = S_FETCH;
            S_FETCH: w_next_state = S_LATCH;
            S_LATCH: begin
                if (w_mem_op == OP_HALT)      w_next_state = S_HALT;
                else if (!is_legal_op(w_mem_op)) w_next_state = S_ERROR;
                else if (has_imm(w_mem_op))   w_next_state = S_FIMM;
                else                          w_next_state = S_ISSUE;
            end
            S_FIMM:  w_next_state = S_LIMM;
            S_LIMM:  w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_EXEC;
            S_EXEC: begin
                // DONE takes priority over a simultaneous watchdog expiry.
                if (DONE) begin
`ifdef SINGLE_STEP_EN
                    w_next_state = S_PAUSE;
`else
                    w_next_state = S_FETCH;
`endif
                end else if (w_expired) begin
                    w_next_state = S_ERROR;
                end
            end
            S_HALT:  if (START) w_next_state = S_FETCH;
            S_ERROR: w_next_state = S_ERROR;
`ifdef SINGLE_STEP_EN
            S_PAUSE: if (STEP) w_next_state = S_FETCH;
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    // Combinational outputs and next values of the registered processor interface.
    always_comb begin
        ADDR       = r_pc;
        BUSY       = !((r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERROR));
        HALTED     = (r_state == S_HALT);
        ERROR      = (r_state == S_ERROR);
        w_run_next = (w_next_state == S_ISSUE) || (w_next_state == S_EXEC);
        w_din_next = '0;
        if ((r_state == S_FIMM) || (r_state == S_LIMM)) begin
            ADDR = r_pc + ADDR_W'(1);
        end
        case (w_next_state)
            // Entering ISSUE from LATCH, the instruction word is still on MEM_DATA.
            S_ISSUE: w_din_next = (r_state == S_LATCH) ? MEM_DATA : r_ir;
            S_EXEC:  w_din_next = has_imm(w_ir_op) ? r_imm : r_ir;
            default: w_din_next = '0;
        endcase
    end

    // State register plus PC, instruction/immediate capture, retire counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_ir          <= '0;
            r_imm         <= '0;
            r_din         <= '0;
            r_run         <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_run   <= w_run_next;
            r_din   <= w_din_next;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (START) begin
                        r_pc          <= '0;
                        r_instr_count <= '0;
                    end
                end
                S_LATCH: r_ir  <= MEM_DATA;
                S_LIMM:  r_imm <= MEM_DATA;
                S_EXEC: begin
                    if (DONE) begin
                        r_pc          <= r_pc + (has_imm(w_ir_op) ? ADDR_W'(2) : ADDR_W'(1));
                        r_instr_count <= r_instr_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DIN         = r_din;
    assign RUN         = r_run;
    assign INSTR_COUNT = r_instr_count;

endmodule

// File: tb/tb_instr_issuer.sv
// Testbench for instr_issuer: cycle table for a single mv + halt program,
// then hand-written sequences for mvi, watchdog, illegal opcode, reset,
// PC/counter wrap and (with SINGLE_STEP_EN) single stepping.
module tb_instr_issuer;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic       DONE;
    logic [4:0] ADDR;
    logic [8:0] MEM_DATA;
    logic [8:0] DIN;
    logic       RUN;
    logic       BUSY;
    logic       HALTED;
    logic       ERROR;
    logic [7:0] INSTR_COUNT;
`ifdef SINGLE_STEP_EN
    logic       STEP;
`endif

    logic [8:0] rom [32];
    int checks;
    int failures;

    instr_issuer u_dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
`ifdef SINGLE_STEP_EN
        .STEP        (STEP),
`endif
        .ADDR        (ADDR),
        .MEM_DATA    (MEM_DATA),
        .DIN         (DIN),
        .RUN         (RUN),
        .DONE        (DONE),
        .BUSY        (BUSY),
        .HALTED      (HALTED),
        .ERROR       (ERROR),
        .INSTR_COUNT (INSTR_COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous program ROM: one-cycle read latency.
    always @(posedge CLK) MEM_DATA <= rom[ADDR];

    typedef struct {
        logic       start;
        logic       done;
        logic       run;
        logic [8:0] din;
        logic [4:0] addr;
        logic       busy;
        logic       halted;
        logic       error;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        START = 1'b0;
        DONE  = 1'b0;
`ifdef SINGLE_STEP_EN
        STEP  = 1'b0;
`endif
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 9'h000;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    // Waits (bounded) for ISSUE, steps into EXEC, answers DONE there.
    task automatic run_instr(output logic [8:0] exec_din);
        int n;
        n = 0;
        while (!RUN && n < 12) begin
            step();
            n++;
        end
        check("run_wait", {31'd0, RUN}, 32'd1);
        step();
        exec_din = DIN;
        DONE = 1'b1;
        step();
        DONE = 1'b0;
    endtask

    initial begin
        logic [8:0] d;
        logic       run_seen;
        checks   = 0;
        failures = 0;

        // ---------------- Test 1: mv then halt, cycle table ----------------
        clear_rom();
        rom[0] = 9'h04B;
        rom[1] = 9'h000;
        do_reset();
        check("rst_run",    {31'd0, RUN},    32'd0);
        check("rst_din",    {23'd0, DIN},    32'd0);
        check("rst_addr",   {27'd0, ADDR},   32'd0);
        check("rst_busy",   {31'd0, BUSY},   32'd0);
        check("rst_halted", {31'd0, HALTED}, 32'd0);
        check("rst_error",  {31'd0, ERROR},  32'd0);
        check("rst_cnt",    {24'd0, INSTR_COUNT}, 32'd0);

        //          start done  run   din     addr  busy  halt  err   cnt
        vecs[0] = '{1'b1, 1'b0, 1'b0, 9'h000, 5'd0, 1'b1, 1'b0, 1'b0, 8'd0}; // FETCH
        vecs[1] = '{1'b0, 1'b0, 1'b0, 9'h000, 5'd0, 1'b1, 1'b0, 1'b0, 8'd0}; // LATCH
        vecs[2] = '{1'b0, 1'b0, 1'b1, 9'h04B, 5'd0, 1'b1, 1'b0, 1'b0, 8'd0}; // ISSUE
        vecs[3] = '{1'b0, 1'b1, 1'b1, 9'h04B, 5'd0, 1'b1, 1'b0, 1'b0, 8'd0}; // DONE in ISSUE ignored -> EXEC
        vecs[4] = '{1'b0, 1'b1, 1'b0, 9'h000, 5'd1, 1'b1, 1'b0, 1'b0, 8'd1}; // DONE in EXEC -> FETCH
        vecs[5] = '{1'b0, 1'b0, 1'b0, 9'h000, 5'd1, 1'b1, 1'b0, 1'b0, 8'd1}; // LATCH
        vecs[6] = '{1'b0, 1'b0, 1'b0, 9'h000, 5'd1, 1'b0, 1'b1, 1'b0, 8'd1}; // HALT
        vecs[7] = '{1'b0, 1'b0, 1'b0, 9'h000, 5'd1, 1'b0, 1'b1, 1'b0, 8'd1}; // stays HALT

        for (int i = 0; i < 8; i++) begin
            START = vecs[i].start;
            DONE  = vecs[i].done;
            step();
            check($sformatf("t1_run[%0d]", i),    {31'd0, RUN},    {31'd0, vecs[i].run});
            if (vecs[i].run)
                check($sformatf("t1_din[%0d]", i), {23'd0, DIN},   {23'd0, vecs[i].din});
            check($sformatf("t1_addr[%0d]", i),   {27'd0, ADDR},   {27'd0, vecs[i].addr});
            check($sformatf("t1_busy[%0d]", i),   {31'd0, BUSY},   {31'd0, vecs[i].busy});
            check($sformatf("t1_halted[%0d]", i), {31'd0, HALTED}, {31'd0, vecs[i].halted});
            check($sformatf("t1_error[%0d]", i),  {31'd0, ERROR},  {31'd0, vecs[i].error});
            check($sformatf("t1_cnt[%0d]", i),    {24'd0, INSTR_COUNT}, {24'd0, vecs[i].cnt});
        end
        START = 1'b0;
        DONE  = 1'b0;

        // Restart from HALT clears HALTED, PC and the retire counter.
        pulse_start();
        check("restart_halted", {31'd0, HALTED}, 32'd0);
        check("restart_busy",   {31'd0, BUSY},   32'd1);
        check("restart_addr",   {27'd0, ADDR},   32'd0);
        check("restart_cnt",    {24'd0, INSTR_COUNT}, 32'd0);

        // ---------------- Test 2: mvi with immediate ----------------
        clear_rom();
        rom[0] = 9'h080;
        rom[1] = 9'h1A5;
        rom[2] = 9'h000;
        do_reset();
        pulse_start();                       // FETCH
        step();                              // LATCH
        step();                              // FIMM
        check("t2_fimm_addr", {27'd0, ADDR}, 32'd1);
        check("t2_fimm_run",  {31'd0, RUN},  32'd0);
        step();                              // LIMM
        check("t2_limm_run",  {31'd0, RUN},  32'd0);
        step();                              // ISSUE: 5th cycle after START
        check("t2_issue_run", {31'd0, RUN},  32'd1);
        check("t2_issue_din", {23'd0, DIN},  32'h080);
        step();                              // EXEC
        check("t2_exec_din",  {23'd0, DIN},  32'h1A5);
        DONE = 1'b1;
        step();                              // FETCH at PC=2
        DONE = 1'b0;
        check("t2_pc",        {27'd0, ADDR}, 32'd2);
        check("t2_run_drop",  {31'd0, RUN},  32'd0);
        step();
        step();
        check("t2_halted",    {31'd0, HALTED}, 32'd1);
        check("t2_cnt",       {24'd0, INSTR_COUNT}, 32'd1);

        // ---------------- Test 3: DONE timeout ----------------
        clear_rom();
        rom[0] = 9'h0DA;
        do_reset();
        pulse_start();
        step();
        step();                              // ISSUE
        for (int i = 0; i < 8; i++) step();  // EXEC cycles 1..8
        check("t3_exec8_run",   {31'd0, RUN},   32'd1);
        check("t3_exec8_error", {31'd0, ERROR}, 32'd0);
        step();
        check("t3_error",       {31'd0, ERROR}, 32'd1);
        check("t3_err_run",     {31'd0, RUN},   32'd0);
        START = 1'b1;
        step();
        step();
        START = 1'b0;
        check("t3_start_ign_err",  {31'd0, ERROR}, 32'd1);
        check("t3_start_ign_busy", {31'd0, BUSY},  32'd0);

        // DONE on the watchdog limit cycle wins over the timeout.
        rom[1] = 9'h000;
        do_reset();
        pulse_start();
        step();
        step();
        for (int i = 0; i < 8; i++) step();
        DONE = 1'b1;
        step();
        DONE = 1'b0;
        check("t3b_error", {31'd0, ERROR}, 32'd0);
        check("t3b_cnt",   {24'd0, INSTR_COUNT}, 32'd1);
        check("t3b_pc",    {27'd0, ADDR}, 32'd1);
        check("t3b_busy",  {31'd0, BUSY}, 32'd1);

        // ---------------- Test 4: illegal opcode ----------------
        clear_rom();
        rom[0] = 9'h140;
        do_reset();
        run_seen = 1'b0;
        START = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            START = 1'b0;
            run_seen |= RUN;
        end
        check("t4_error",    {31'd0, ERROR},    32'd1);
        check("t4_run_seen", {31'd0, run_seen}, 32'd0);

        // ---------------- Test 5: reset mid-execution ----------------
        clear_rom();
        rom[0] = 9'h0DA;
        do_reset();
        pulse_start();
        step();
        step();
        step();                              // EXEC
        check("t5_in_exec", {31'd0, RUN}, 32'd1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("t5_run",  {31'd0, RUN},  32'd0);
        check("t5_din",  {23'd0, DIN},  32'd0);
        check("t5_addr", {27'd0, ADDR}, 32'd0);
        check("t5_busy", {31'd0, BUSY}, 32'd0);
        pulse_start();
        step();
        step();
        check("t5_rerun_run", {31'd0, RUN}, 32'd1);
        check("t5_rerun_din", {23'd0, DIN}, 32'h0DA);

        // ---------------- PC and retire-counter wrap ----------------
        clear_rom();
        for (int i = 0; i < 31; i++) rom[i] = 9'h04B;
        rom[31] = 9'h080;                     // mvi whose immediate wraps to rom[0]
        do_reset();
        pulse_start();
        for (int i = 0; i < 31; i++) run_instr(d);
        run_instr(d);
        check("wrap_imm", {23'd0, d}, 32'h04B);
        check("wrap_pc",  {27'd0, ADDR}, 32'd1);
        check("wrap_cnt", {24'd0, INSTR_COUNT}, 32'd32);
        for (int i = 0; i < 224; i++) run_instr(d);
        check("cnt_wrap", {24'd0, INSTR_COUNT}, 32'd0);

`ifdef SINGLE_STEP_EN
        // ---------------- Test 6: single step ----------------
        clear_rom();
        rom[0] = 9'h04B;
        rom[1] = 9'h04B;
        rom[2] = 9'h000;
        do_reset();
        pulse_start();
        run_instr(d);                         // now in PAUSE
        check("t6_pause_busy", {31'd0, BUSY}, 32'd1);
        check("t6_pause_run",  {31'd0, RUN},  32'd0);
        step();
        step();
        check("t6_hold_run",   {31'd0, RUN},  32'd0);
        check("t6_hold_addr",  {27'd0, ADDR}, 32'd1);
        STEP = 1'b1;
        step();                               // FETCH
        STEP = 1'b0;
        check("t6_s1_run", {31'd0, RUN}, 32'd0);
        step();                               // LATCH
        check("t6_s2_run", {31'd0, RUN}, 32'd0);
        step();                               // ISSUE
        check("t6_s3_run", {31'd0, RUN}, 32'd1);
        check("t6_s3_din", {23'd0, DIN}, 32'h04B);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
